// File: rtl/vram_port_arbiter.sv
// Round-robin arbiter sharing VRAM port B among N_REQ requesters, with read-valid tracking.
// Define VRAM_ARB_LOCK_EN to enable burst locking through the lock inputs.
module vram_port_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned RD_LAT = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         we,
  input  logic [N_REQ*ADDR_W-1:0]  addr,
  input  logic [N_REQ*DATA_W-1:0]  wdata,
  input  logic [N_REQ-1:0]         lock,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic [ADDR_W-1:0]        ram_address,
  output logic                     ram_wren,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata
);

  localparam int unsigned PtrW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PtrW-1:0]   ptr_q;
  logic [ADDR_W-1:0] ram_address_q;
  logic              ram_wren_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [N_REQ-1:0]  rvalid_q;
  logic [RD_LAT-1:0] pv_q;
  logic [PtrW-1:0]   pid_q [RD_LAT];

  logic              rr_vld;
  logic [PtrW-1:0]   rr_idx;
  int unsigned       cand;
  logic              sel_vld;
  logic [PtrW-1:0]   sel_idx;
  logic [PtrW-1:0]   ptr_next;
  logic              use_owner;

  always_comb begin
    rr_vld = 1'b0;
    rr_idx = '0;
    cand   = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!rr_vld && req[cand[PtrW-1:0]]) begin
        rr_vld = 1'b1;
        rr_idx = cand[PtrW-1:0];
      end
    end
  end

`ifdef VRAM_ARB_LOCK_EN
  logic            owner_vld_q;
  logic [PtrW-1:0] owner_q;
  logic [12:0]     burst_q;    // saturates at 4096 consecutive owner grants
  logic            others_pending;

  always_comb begin
    others_pending = |(req & ~(N_REQ'(1) << owner_q));
    use_owner = owner_vld_q && req[owner_q] && lock[owner_q] &&
                !(burst_q[12] && others_pending);
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock;
  assign use_owner   = 1'b0;
`endif

  always_comb begin
`ifdef VRAM_ARB_LOCK_EN
    sel_vld = use_owner ? 1'b1 : rr_vld;
    sel_idx = use_owner ? owner_q : rr_idx;
`else
    sel_vld = rr_vld;
    sel_idx = rr_idx;
`endif
    ptr_next = PtrW'((32'(sel_idx) + 1) % N_REQ);
    gnt      = (sel_vld && !reset) ? (N_REQ'(1) << sel_idx) : '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr_q         <= '0;
      ram_address_q <= '0;
      ram_wren_q    <= 1'b0;
      ram_wdata_q   <= '0;
      rvalid_q      <= '0;
      pv_q          <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) pid_q[i] <= '0;
`ifdef VRAM_ARB_LOCK_EN
      owner_vld_q   <= 1'b0;
      owner_q       <= '0;
      burst_q       <= '0;
`endif
    end else begin
      ram_wren_q <= sel_vld & we[sel_idx];
      if (sel_vld) begin
        ram_address_q <= addr[32'(sel_idx)*ADDR_W +: ADDR_W];
        ram_wdata_q   <= wdata[32'(sel_idx)*DATA_W +: DATA_W];
      end
      if (sel_vld && !use_owner) ptr_q <= ptr_next;

      for (int unsigned i = RD_LAT - 1; i >= 1; i--) begin
        pv_q[i]  <= pv_q[i-1];
        pid_q[i] <= pid_q[i-1];
      end
      pv_q[0]  <= sel_vld & ~we[sel_idx];
      pid_q[0] <= sel_idx;
      rvalid_q <= pv_q[RD_LAT-1] ? (N_REQ'(1) << pid_q[RD_LAT-1]) : '0;

`ifdef VRAM_ARB_LOCK_EN
      if (use_owner) begin
        if (!burst_q[12]) burst_q <= burst_q + 13'd1;
      end else if (sel_vld && lock[sel_idx]) begin
        owner_vld_q <= 1'b1;
        owner_q     <= sel_idx;
        burst_q     <= 13'd1;
      end else begin
        owner_vld_q <= 1'b0;
        burst_q     <= '0;
      end
`endif
    end
  end

  assign ram_address = ram_address_q;
  assign ram_wren    = ram_wren_q;
  assign ram_wdata   = ram_wdata_q;
  assign rvalid      = rvalid_q;
  assign rdata       = ram_rdata;

endmodule
